// File: rtl/mic_spi_sampler_pkg.sv
// mic_pkg: shared types and default geometry for the microphone ADC sampler.
//   mic_state_t      : sampler FSM states (QUIET, ARM, SHIFT, DONE)
//   MIC_DATA_W       : ADC sample width
//   MIC_FRAME_BITS   : sclk rising edges per chip-select-low frame
//   MIC_LEAD_ZEROS   : zero bits the ADC sends ahead of the sample MSB
//   MIC_QUIET_EDGES  : sclk rising edges with cs_n high between frames
package mic_pkg;

  typedef enum logic [1:0] {
    QUIET = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mic_state_t;

  localparam int MIC_DATA_W      = 12;
  localparam int MIC_FRAME_BITS  = 16;
  localparam int MIC_LEAD_ZEROS  = 3;
  localparam int MIC_QUIET_EDGES = 4;

endpackage

// File: rtl/mic_spi_sampler_edge_detect.sv
// edge_detect: registers a same-domain level and flags its transitions.
//   clk    : clock
//   srst   : synchronous active-high reset (clears the delayed copy)
//   sig_in : level to watch
//   rise   : combinational, high while sig_in=1 and the delayed copy is 0
//   fall   : combinational, high while sig_in=0 and the delayed copy is 1
//   sig_q  : sig_in delayed by one clk cycle
module edge_detect (
  input  logic clk,
  input  logic srst,
  input  logic sig_in,
  output logic rise,
  output logic fall,
  output logic sig_q
);

  logic sig_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sig_reg <= 1'b0;
    end else begin
      sig_reg <= sig_in;
    end
  end

  assign rise  = sig_in & ~sig_reg;
  assign fall  = ~sig_in & sig_reg;
  assign sig_q = sig_reg;

endmodule

// File: rtl/mic_spi_sampler.sv
// mic_spi_sampler: runs the SPI read cycle of a 12-bit microphone ADC off the
// divided serial clock and hands each sample downstream over valid/ready.
//   inClock      : system clock (sole clock domain)
//   reset        : synchronous active-high reset
//   sclkIn       : divided clock from the divider, treated as data
//   miso         : ADC serial data, MSB first
//   cs_n         : ADC chip select, active-low
//   sclk         : ADC serial clock, sclkIn delayed one inClock cycle
//   sample       : captured sample (two's complement when SIGNED_OUT=1)
//   sample_valid : sample available
//   sample_ready : consumer accepts sample
//   overrun      : sticky, a sample was overwritten before being accepted
module mic_spi_sampler
  import mic_pkg::*;
#(
  parameter int DATA_W      = MIC_DATA_W,
  parameter int FRAME_BITS  = MIC_FRAME_BITS,
  parameter int LEAD_ZEROS  = MIC_LEAD_ZEROS,
  parameter int QUIET_EDGES = MIC_QUIET_EDGES,
  parameter int SIGNED_OUT  = 1
) (
  input  logic              inClock,
  input  logic              reset,
  input  logic              sclkIn,
  input  logic              miso,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  localparam int BIT_CNT_W   = $clog2(FRAME_BITS + 1);
  localparam int QUIET_CNT_W = $clog2(QUIET_EDGES + 1);
  // The leading zeros fall off the top of the shifter; only the sample
  // window and the trailing bits below it are kept.
  localparam int SHIFT_W     = FRAME_BITS - LEAD_ZEROS;

  localparam logic [BIT_CNT_W-1:0]   BIT_LAST   = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0]   BIT_ONE    = BIT_CNT_W'(1);
  localparam logic [QUIET_CNT_W-1:0] QUIET_LAST = QUIET_CNT_W'(QUIET_EDGES - 1);
  localparam logic [QUIET_CNT_W-1:0] QUIET_ONE  = QUIET_CNT_W'(1);

  logic rise_c, fall_c, sclk_q;
  logic primed_reg, rise_reg, fall_reg;

  mic_state_t             state_reg, state_next;
  logic [QUIET_CNT_W-1:0] quiet_cnt_reg, quiet_cnt_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [SHIFT_W-1:0]     shift_reg, shift_next;
  logic                   cs_n_reg, cs_n_next;
  logic                   capture;

  logic [DATA_W-1:0] raw, sample_cap;
  logic [DATA_W-1:0] sample_reg;
  logic              valid_reg, overrun_reg;

  edge_detect u_sclk_edge (
    .clk    (inClock),
    .srst   (reset),
    .sig_in (sclkIn),
    .rise   (rise_c),
    .fall   (fall_c),
    .sig_q  (sclk_q)
  );

  // Edge strobes are registered once. The delayed copy is cleared by reset,
  // so the first cycle afterwards would report a false rise if sclkIn is
  // high; primed_reg masks that cycle.
  always_ff @(posedge inClock) begin
    if (reset) begin
      primed_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      primed_reg <= 1'b1;
      rise_reg   <= rise_c & primed_reg;
      fall_reg   <= fall_c & primed_reg;
    end
  end

  always_ff @(posedge inClock) begin
    if (reset) begin
      state_reg     <= QUIET;
      quiet_cnt_reg <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      cs_n_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      quiet_cnt_reg <= quiet_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      cs_n_reg      <= cs_n_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    quiet_cnt_next = quiet_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    capture        = 1'b0;
    case (state_reg)
      QUIET: begin
        if (rise_reg) begin
          if (quiet_cnt_reg == QUIET_LAST) begin
            quiet_cnt_next = '0;
            state_next     = ARM;
          end else begin
            quiet_cnt_next = quiet_cnt_reg + QUIET_ONE;
          end
        end
      end
      ARM: begin
        // Dropping cs_n on a falling edge lets the ADC present its first
        // bit before the first rising edge of the frame.
        if (fall_reg) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_reg) begin
          shift_next   = {shift_reg[SHIFT_W-2:0], miso};
          bit_cnt_next = bit_cnt_reg + BIT_ONE;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        capture      = 1'b1;
        bit_cnt_next = '0;
        state_next   = QUIET;
      end
      default: begin
        state_next = QUIET;
      end
    endcase
    // cs_n follows the state being entered so it is a clean register output.
    cs_n_next = (state_next != SHIFT);
  end

  assign raw = shift_reg[SHIFT_W-1 -: DATA_W];

  // Offset-binary to two's complement is an MSB inversion.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fmt
    if (SIGNED_OUT != 0 && gi == DATA_W - 1) begin : g_inv
      assign sample_cap[gi] = ~raw[gi];
    end else begin : g_pass
      assign sample_cap[gi] = raw[gi];
    end
  end

  always_ff @(posedge inClock) begin
    if (reset) begin
      sample_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (capture) begin
      sample_reg <= sample_cap;
      valid_reg  <= 1'b1;
      // A capture coinciding with a transfer replaces an accepted sample.
      if (valid_reg && !sample_ready) begin
        overrun_reg <= 1'b1;
      end
    end else if (valid_reg && sample_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign cs_n         = cs_n_reg;
  assign sclk         = sclk_q;
  assign sample       = sample_reg;
  assign sample_valid = valid_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_mic_spi_sampler.sv
// tb_mic_spi_sampler: drives a divided sclk and an ADC frame model into two
// sampler instances (raw and signed output) and compares every cycle against
// a transaction-level reference of the capture/handshake rules.
module tb_mic_spi_sampler;

  localparam int HALF_RUN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sclk_in, miso, sample_ready;
  logic        cs_n_raw, sclk_raw, valid_raw, ovr_raw;
  logic [11:0] sample_raw;
  logic        cs_n_sgn, sclk_sgn, valid_sgn, ovr_sgn;
  logic [11:0] sample_sgn;

  mic_spi_sampler #(
    .DATA_W(12), .FRAME_BITS(16), .LEAD_ZEROS(3), .QUIET_EDGES(4), .SIGNED_OUT(0)
  ) dut_raw (
    .inClock(clk), .reset(reset), .sclkIn(sclk_in), .miso(miso),
    .cs_n(cs_n_raw), .sclk(sclk_raw), .sample(sample_raw),
    .sample_valid(valid_raw), .sample_ready(sample_ready), .overrun(ovr_raw)
  );

  mic_spi_sampler #(
    .DATA_W(12), .FRAME_BITS(16), .LEAD_ZEROS(3), .QUIET_EDGES(4), .SIGNED_OUT(1)
  ) dut_sgn (
    .inClock(clk), .reset(reset), .sclkIn(sclk_in), .miso(miso),
    .cs_n(cs_n_sgn), .sclk(sclk_sgn), .sample(sample_sgn),
    .sample_valid(valid_sgn), .sample_ready(sample_ready), .overrun(ovr_sgn)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int half = 1;
  int phase_cnt = 0;
  int rises_in_frame = 0;
  int rises_since_reset = 0;
  int frames_done = 0;
  int cap_cycle = 0;
  int ready_mode = 0;  // 0 fixed, 1 random, 2 only in the capture cycle
  bit sclk_run = 1'b1;
  bit cap_pending = 1'b0;
  bit frame_abort = 1'b0;
  bit ready_fixed = 1'b1;

  logic [11:0] adc_data = 12'h000;
  logic [11:0] cap_data = 12'h000;
  logic [11:0] m_sample = 12'h000;
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Offset binary minus mid-scale gives the two's complement value.
  function automatic logic [11:0] to_twos(input logic [11:0] v);
    return v - 12'd2048;
  endfunction

  // One inClock cycle: update the reference at the edge, compare outputs 1
  // time unit later, then drive the next inputs.
  task automatic step();
    logic        rst_seen, sclk_seen;
    logic [15:0] frame;
    @(posedge clk);
    cyc++;
    rst_seen  = reset;
    sclk_seen = sclk_in;
    if (rst_seen) begin
      m_valid = 1'b0;
      m_ovr = 1'b0;
      m_sample = 12'h000;
      cap_pending = 1'b0;
    end else if (cap_pending && cyc == cap_cycle) begin
      if (m_valid && !sample_ready) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_sample = cap_data;
      cap_pending = 1'b0;
    end else if (m_valid && sample_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("sclk_delay", sclk_raw, rst_seen ? 1'b0 : sclk_seen);
    check("valid_raw", valid_raw, m_valid);
    check("valid_sgn", valid_sgn, m_valid);
    check("overrun_raw", ovr_raw, m_ovr);
    check("overrun_sgn", ovr_sgn, m_ovr);
    if (m_valid) begin
      check("sample_raw", sample_raw, m_sample);
      check("sample_sgn", sample_sgn, to_twos(m_sample));
    end
    if (cs_n_raw) begin
      if (rises_in_frame != 0 && !frame_abort) check("cs_low_rises", rises_in_frame, 16);
      rises_in_frame = 0;
      frame_abort = 1'b0;
    end
    case (ready_mode)
      1:       sample_ready = 1'($urandom_range(0, 1));
      2:       sample_ready = cap_pending && (cap_cycle == cyc + 1);
      default: sample_ready = ready_fixed;
    endcase
    if (sclk_run) begin
      phase_cnt++;
      if (phase_cnt >= half) begin
        phase_cnt = 0;
        sclk_in = ~sclk_in;
        if (sclk_in) begin
          if (!reset) rises_since_reset++;
          if (!cs_n_raw) begin
            rises_in_frame++;
            if (rises_in_frame == 16) begin
              cap_pending = 1'b1;
              cap_cycle = cyc + 3;
              cap_data = adc_data;
              frames_done++;
            end
          end
        end else begin
          // ADC presents the next frame bit after each falling edge.
          if (!cs_n_raw && rises_in_frame > 0 && rises_in_frame < 16) begin
            frame = {3'b000, adc_data, 1'b0};
            miso = frame[15 - rises_in_frame];
          end else begin
            miso = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic run_frame(input logic [11:0] d, input int stall_at);
    int target;
    int n;
    bit stalled;
    target = frames_done + 1;
    n = 0;
    stalled = 1'b0;
    adc_data = d;
    while ((frames_done < target || cap_pending) && n < 1500) begin
      step();
      n++;
      if (stall_at > 0 && !stalled && rises_in_frame == stall_at) begin
        stalled = 1'b1;
        sclk_run = 1'b0;
        repeat (200) step();
        check("stall_cs_n", cs_n_raw, 1'b0);
        sclk_run = 1'b1;
      end
    end
    check("frame_done", (frames_done >= target) && !cap_pending, 1'b1);
    check("valid_at_latency", valid_raw, 1'b1);
    check("frame_sample_raw", sample_raw, d);
    check("frame_sample_sgn", sample_sgn, to_twos(d));
    $display("frame data=0x%03h raw=0x%03h sgn=0x%03h overrun=%0d cycle=%0d",
             d, sample_raw, sample_sgn, ovr_raw, cyc);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sclk_in = 1'b0;
    miso = 1'b0;
    sample_ready = 1'b1;
    adc_data = 12'hA5C;
    half = 1;

    // Reset held with sclkIn toggling every cycle.
    repeat (3) begin
      step();
      check("rst_cs_n", cs_n_raw, 1'b1);
      check("rst_sclk", sclk_raw, 1'b0);
      check("rst_valid", valid_raw, 1'b0);
      check("rst_overrun", ovr_raw, 1'b0);
    end
    reset = 1'b0;
    half = HALF_RUN;
    phase_cnt = 0;
    rises_since_reset = 0;

    n = 0;
    while (cs_n_raw && n < 400) begin
      step();
      n++;
    end
    check("first_cs_fall", cs_n_raw, 1'b0);
    check("quiet_rises_first", rises_since_reset >= 4, 1'b1);

    // Reference frame 0xA5C, ready held high.
    run_frame(12'hA5C, 0);

    // Held sample, then ready only in the cycle the next capture lands.
    ready_fixed = 1'b0;
    run_frame(12'($urandom_range(0, 4095)), 0);
    ready_mode = 2;
    run_frame(12'($urandom_range(0, 4095)), 0);
    check("exact_xfer_overrun", ovr_raw, 1'b0);
    ready_mode = 0;
    ready_fixed = 1'b1;
    step();
    step();

    // Overwrite before acceptance.
    ready_fixed = 1'b0;
    run_frame(12'h7FF, 0);
    run_frame(12'h001, 0);
    check("ovr_sample", sample_raw, 12'h001);
    check("ovr_valid", valid_raw, 1'b1);
    check("ovr_flag", ovr_raw, 1'b1);
    ready_fixed = 1'b1;
    step();
    step();
    check("ovr_valid_drop", valid_raw, 1'b0);
    check("ovr_sticky", ovr_raw, 1'b1);

    // sclkIn frozen mid-frame after bit 9.
    run_frame(12'($urandom_range(0, 4095)), 9);

    // Reset after 7 shifted bits discards the frame.
    adc_data = 12'($urandom_range(0, 4095));
    n = 0;
    while (rises_in_frame != 7 && n < 1000) begin
      step();
      n++;
    end
    check("reach_bit7", rises_in_frame, 7);
    step();
    step();
    frame_abort = 1'b1;
    reset = 1'b1;
    step();
    check("midreset_cs_n", cs_n_raw, 1'b1);
    reset = 1'b0;
    run_frame(12'h123, 0);

    // Random data with random ready.
    ready_mode = 1;
    repeat (6) run_frame(12'($urandom_range(0, 4095)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic_spi_sampler.md
Name: mic_spi_sampler

Overview:
- Consumes the divided serial clock from the clock divider and runs the SPI read cycle of the 12-bit microphone ADC. The ADC frame is 3 leading zeros, 12 data bits, and 1 trailing zero.
- Emits one sample per frame to the downstream FFT/visualizer input over a valid/ready handshake.
- Runs entirely in the inClock domain and treats the divider output as a data signal that it edge-detects.

Parameters:
- DATA_W, 12, ADC sample width.
- FRAME_BITS, 16, sclk rising edges per CS-low frame.
- LEAD_ZEROS, 3, leading zero bits preceding the sample MSB.
- QUIET_EDGES, 4, sclk rising edges with cs_n high between frames (minimum 1).
- SIGNED_OUT, 1, 1 = convert offset-binary to two's complement by inverting the MSB; 0 = raw.

Ports:
- inClock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sclkIn  in  1  divided clock from the divider; same domain, registered at source.
- miso  in  1  ADC serial data.
- cs_n  out  1  ADC chip select, active-low.
- sclk  out  1  ADC serial clock; equals sclkIn delayed 1 inClock cycle.
- sample  out  DATA_W  captured sample.
- sample_valid  out  1  sample available.
- sample_ready  in  1  consumer accepts sample.
- overrun  out  1  sticky: a sample was overwritten before it was accepted.

Behaviour:
- Interface: one clock, inClock. reset is synchronous and active-high.
- Reset values: cs_n=1, sclk=0, sample=0, sample_valid=0, overrun=0, FSM=QUIET, quiet count=0, bit count=0, shift register=0.
- Edge detect:
  - sclk_q <= sclkIn.
  - rise = sclkIn & ~sclk_q.
  - fall = ~sclkIn & sclk_q.
  - sclk output = sclk_q.
- FSM states:
  - QUIET: cs_n=1. Count rises. When count reaches QUIET_EDGES, clear the count and go to ARM.
  - ARM: cs_n=1. On the next fall, go to SHIFT; cs_n drives 0 from the following cycle.
  - SHIFT: cs_n=0. On each rise, shift_reg <= {shift_reg[FRAME_BITS-2:0], miso} and increment the bit count. On the rise that completes bit FRAME_BITS, go to DONE.
  - DONE: lasts 1 cycle. cs_n=1. Capture the sample, clear the bit count, go to QUIET.
- Capture:
  - raw = shift_reg[FRAME_BITS-1-LEAD_ZEROS -: DATA_W].
  - If SIGNED_OUT, sample = {~raw[DATA_W-1], raw[DATA_W-2:0]}.
  - sample and sample_valid update on the cycle after DONE is entered.
  - Latency from the final sclkIn rise to sample_valid: 3 inClock cycles (edge register, DONE, output register).
- Handshake:
  - Transfer occurs when sample_valid & sample_ready; sample_valid drops the next cycle unless a new capture lands in that same cycle.
  - sample holds stable while valid and not accepted.
  - Capture while valid and not ready: sample is overwritten, valid stays 1, overrun <= 1.
  - Capture in the same cycle as a transfer: valid stays 1, new sample loads, no overrun.
  - overrun clears only on reset.
- Frame timing: with defaults, one frame is 20 sclk periods (16 shift + 4 quiet).
- Boundary conditions:
  - Reset mid-frame: cs_n=1 on the next edge; the partial frame is discarded; no sample_valid pulse. The first frame after reset starts only after QUIET_EDGES rises.
  - sclkIn stalled (divider in reset or speed change): the FSM holds its state and counts; no timeout. It resumes on the next edges.
  - rise and fall are mutually exclusive, so no simultaneous-edge case exists.
  - The bit counter is sized $clog2(FRAME_BITS+1) and never wraps.

Decomposition:
- Package mic_pkg:
  - state enum {QUIET, ARM, SHIFT, DONE}.
  - localparam defaults for DATA_W, FRAME_BITS, LEAD_ZEROS.
- Sub-module edge_detect: sig_in to rise/fall pulses plus the delayed copy. It is reused for button inputs elsewhere.

Test Plan:
- Reset held 3 cycles with sclkIn toggling -> cs_n=1, sclk=0, sample_valid=0, overrun=0 throughout. The first cs_n fall occurs only after 4 sclkIn rises post-reset.
- sclkIn period 8 cycles, sample_ready=1, ADC model sends data 0xA5C (frame 0x14B8):
  - SIGNED_OUT=0 -> sample=0xA5C.
  - SIGNED_OUT=1 -> sample=0x25C.
  - In both cases sample_valid rises exactly 3 cycles after the 16th sclkIn rise; cs_n low for exactly 16 rises.
- Frames 0x7FF then 0x001 with sample_ready=0 -> after frame 2: sample=0x001 (raw), sample_valid=1, overrun=1. Raise ready -> valid drops next cycle; overrun stays 1.
- Ready asserted in the exact cycle the second capture lands -> first sample transfers, second loads, overrun=0.
- reset pulsed after 7 shifted bits -> cs_n=1 next cycle, no valid pulse. The next full frame with data 0x123 returns 0x123 (raw mode).
- sclkIn frozen for 200 cycles after bit 9 -> cs_n stays 0, no valid. On resume, the frame completes with the correct sample.
